// File: rtl/display_compositor.sv
// Priority compositor for NUM_LAYERS overlay streams over a camera background, with the
// START/PLAY/OVER screen FSM, frame-synchronous hit tint and a 2-stage pixel pipeline.
module display_compositor #(
  parameter int          NUM_LAYERS   = 6,
  parameter int          FIELD_XMAX   = 960,
  parameter int          FIELD_YMAX   = 640,
  parameter logic [23:0] BORDER_COLOR = 24'hFF_FF_FF,
  parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
  parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic                     nf_in,
  input  logic [24*NUM_LAYERS-1:0] layer_pixel_in,
  input  logic [NUM_LAYERS-1:0]    layer_valid_in,
  input  logic [23:0]              camera_pixel_in,
  input  logic                     camera_en_in,
  input  logic [23:0]              start_pixel_in,
  input  logic [31:0]              ir_in,
  input  logic                     ir_valid_in,
  input  logic                     hit_in,
  input  logic                     game_over_in,
  output logic [23:0]              pixel_out,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic [1:0]               screen_state_out
);

  // state    | meaning
  // ST_START | start menu image shown, waiting for a start IR code
  // ST_PLAY  | game running, composite shown, hits tint the field
  // ST_OVER  | game ended, dimmed composite, start IR code returns to menu
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam logic [11:0] L_XMAX  = 12'(FIELD_XMAX);
  localparam logic [10:0] L_YMAX  = 11'(FIELD_YMAX);
  localparam logic [3:0]  L_FLASH = 4'(FLASH_FRAMES);

  state_t      r_state, w_state_next;
  state_t      r_pend_tgt, w_pend_tgt_next;
  logic        r_pend, w_pend_next;
  logic [3:0]  r_flash, w_flash_next;
  logic        w_ir_match;

  logic [23:0] w_comp;
  logic [11:0] w_h12;
  logic [10:0] w_v11;
  logic        w_border, w_oof;

  logic [23:0] r_s1_comp, r_s1_start;
  logic        r_s1_border, r_s1_oof;
  logic [10:0] r_s1_h;
  logic [9:0]  r_s1_v;

  logic [23:0] w_tint, w_half, w_pix;
  logic [23:0] r_pixel;
  logic [10:0] r_h2;
  logic [9:0]  r_v2;

  assign w_ir_match = ir_valid_in && ((ir_in == START_CODE_A) || (ir_in == START_CODE_B));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_START;
      r_pend     <= 1'b0;
      r_pend_tgt <= ST_START;
      r_flash    <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_pend     <= w_pend_next;
      r_pend_tgt <= w_pend_tgt_next;
      r_flash    <= w_flash_next;
    end
  end

  // Requests latch until the frame edge; the target follows from the current state,
  // so repeated requests in one frame collapse into a single step.
  always_comb begin
    w_state_next    = r_state;
    w_pend_next     = r_pend;
    w_pend_tgt_next = r_pend_tgt;
    case (r_state)
      ST_START: if (w_ir_match) begin
        w_pend_next     = 1'b1;
        w_pend_tgt_next = ST_PLAY;
      end
      ST_PLAY: if (game_over_in) begin
        w_pend_next     = 1'b1;
        w_pend_tgt_next = ST_OVER;
      end
      ST_OVER: if (w_ir_match) begin
        w_pend_next     = 1'b1;
        w_pend_tgt_next = ST_START;
      end
      default: begin
        w_pend_next     = 1'b0;
        w_pend_tgt_next = ST_START;
        w_state_next    = ST_START;
      end
    endcase
    if (nf_in && w_pend_next) begin
      w_state_next = w_pend_tgt_next;
      w_pend_next  = 1'b0;
    end
  end

  always_comb begin
    w_flash_next = r_flash;
    if (r_state == ST_PLAY && w_state_next != ST_PLAY) begin
      w_flash_next = 4'd0;
    end else if (r_state == ST_PLAY && hit_in) begin
      w_flash_next = L_FLASH;
    end else if (nf_in && r_flash != 4'd0) begin
      w_flash_next = r_flash - 4'd1;
    end
  end

  // Lowest-index valid layer wins, so scan from the top index down.
  always_comb begin
    w_comp = camera_en_in ? camera_pixel_in : 24'h0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid_in[i]) w_comp = layer_pixel_in[24*i +: 24];
    end
  end

  assign w_h12    = {1'b0, hcount_in};
  assign w_v11    = {1'b0, vcount_in};
  assign w_border = ((w_h12 == L_XMAX) && (w_v11 <= L_YMAX)) ||
                    ((w_v11 == L_YMAX) && (w_h12 <= L_XMAX));
  assign w_oof    = (w_h12 > L_XMAX) || (w_v11 > L_YMAX);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_s1_comp   <= 24'h0;
      r_s1_start  <= 24'h0;
      r_s1_border <= 1'b0;
      r_s1_oof    <= 1'b0;
      r_s1_h      <= 11'h0;
      r_s1_v      <= 10'h0;
    end else begin
      r_s1_comp   <= w_comp;
      r_s1_start  <= start_pixel_in;
      r_s1_border <= w_border;
      r_s1_oof    <= w_oof;
      r_s1_h      <= hcount_in;
      r_s1_v      <= vcount_in;
    end
  end

  assign w_tint = {8'hFF, 1'b0, r_s1_comp[15:9], 1'b0, r_s1_comp[7:1]};
  assign w_half = {1'b0, r_s1_comp[23:17], 1'b0, r_s1_comp[15:9], 1'b0, r_s1_comp[7:1]};

  always_comb begin
    w_pix = 24'h0;
    case (r_state)
      ST_START: w_pix = r_s1_start;
      ST_PLAY: begin
        if (r_s1_border)          w_pix = BORDER_COLOR;
        else if (r_s1_oof)        w_pix = 24'h0;
        else if (r_flash != 4'd0) w_pix = w_tint;
        else                      w_pix = r_s1_comp;
      end
      ST_OVER: begin
        if (r_s1_border)   w_pix = BORDER_COLOR;
        else if (r_s1_oof) w_pix = 24'h0;
        else               w_pix = w_half;
      end
      default: w_pix = 24'h0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_pixel <= 24'h0;
      r_h2    <= 11'h0;
      r_v2    <= 10'h0;
    end else begin
      r_pixel <= w_pix;
      r_h2    <= r_s1_h;
      r_v2    <= r_s1_v;
    end
  end

  assign pixel_out        = r_pixel;
  assign hcount_out       = r_h2;
  assign vcount_out       = r_v2;
  assign screen_state_out = r_state;

endmodule

// File: doc/display_compositor.md
Name: display_compositor

Overview:
- Parametrised successor to the fixed-layer game display path: priority-composites NUM_LAYERS sprite/overlay pixel streams over an optional camera background.
- Owns the screen state machine (START/PLAY/OVER) driven by IR remote codes and game events.
- Adds a frame-synchronous hit-flash tint and a 2-stage registered pipeline with matching delayed counts.
- Sits between the sprite generators and the video output/TMDS stage.

Parameters:
- NUM_LAYERS, 6, number of overlay layers; index 0 has highest priority.
- FIELD_XMAX, 960, horizontal position of the play-field border line.
- FIELD_YMAX, 640, vertical position of the play-field border line.
- BORDER_COLOR, 24'hFF_FF_FF, colour of the border line.
- START_CODE_A, 32'h20DF_5BA4, IR code that advances the screen state.
- START_CODE_B, 32'h20DF_5AA5, alternate IR code with the same effect.
- FLASH_FRAMES, 8, number of frames the hit tint lasts; 4-bit counter, range 1..15.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  reset; synchronous, active-low.
- hcount_in  input  11  current pixel x.
- vcount_in  input  10  current pixel y.
- nf_in  input  1  new-frame pulse, one cycle.
- layer_pixel_in  input  24*NUM_LAYERS  layer i occupies bits [24i+23:24i].
- layer_valid_in  input  NUM_LAYERS  layer i is opaque at this pixel.
- camera_pixel_in  input  24  background pixel.
- camera_en_in  input  1  enables the camera background; when low the background is black.
- start_pixel_in  input  24  start-menu image pixel.
- ir_in  input  32  last decoded IR code.
- ir_valid_in  input  1  one-cycle strobe indicating ir_in is new.
- hit_in  input  1  player-damage pulse.
- game_over_in  input  1  level signal: a health value reached zero.
- pixel_out  output  24  composited pixel.
- hcount_out  output  11  hcount_in delayed by 2 cycles.
- vcount_out  output  10  vcount_in delayed by 2 cycles.
- screen_state_out  output  2  current state: 0=START, 1=PLAY, 2=OVER.

Behaviour:
- Reset (rst_n_in low at a clock edge): pixel_out, hcount_out, vcount_out = 0; state = START; pending request cleared; flash counter = 0; pipeline registers = 0.
- Reset mid-frame takes effect on the next edge with no partial-frame carryover.
- Pipeline latency is exactly 2 cycles from hcount_in/vcount_in/pixel inputs to pixel_out/hcount_out/vcount_out.
- Stage 1, layer select: pick the lowest index i with layer_valid_in[i]=1. If no layer is valid, use camera_pixel_in when camera_en_in=1, else 24'h0.
- Stage 1 also registers start_pixel_in, a border flag, and an out-of-field flag.
  - Border flag: (h==FIELD_XMAX && v<=FIELD_YMAX) || (v==FIELD_YMAX && h<=FIELD_XMAX).
  - Out-of-field flag: h>FIELD_XMAX || v>FIELD_YMAX.
- Stage 2, by state:
  - START: output the registered start pixel.
  - PLAY: border wins with BORDER_COLOR; otherwise out-of-field outputs 0; otherwise the composite. When the flash counter is nonzero, the in-field composite becomes {8'hFF, G>>1, B>>1}. Border is never tinted.
  - OVER: same as PLAY but with no tint, and every in-field channel is halved (>>1).
- Screen state transitions are requested asynchronously to the frame but committed only on the cycle nf_in=1; state registers on that edge.
  - START: ir_valid_in with ir_in equal to START_CODE_A or START_CODE_B sets pending=PLAY.
  - PLAY: game_over_in=1 sets pending=OVER. IR codes are ignored in PLAY.
  - OVER: a matching IR strobe sets pending=START.
  - A request arriving in the same cycle as nf_in commits on that edge.
  - Multiple requests within one frame collapse into a single transition; states are never skipped.
- Flash counter:
  - hit_in in PLAY loads FLASH_FRAMES, and reloads if already running.
  - Each nf_in decrements the counter when nonzero.
  - hit_in and nf_in in the same cycle: the load wins.
  - The counter clears to 0 when the state leaves PLAY.
  - hit_in outside PLAY is ignored.
- Width rules: all comparisons are unsigned. hcount_in is zero-extended to 12 bits for comparison against FIELD_XMAX.
- screen_state_out reflects the committed state; it is not pipeline-delayed.

Test Plan:
- Reset check: hold rst_n_in=0 for 3 cycles with random inputs -> pixel_out=0, screen_state_out=0, hcount_out=0.
- Priority: layer_valid_in=6'b001010, layer1=24'h00FF00, layer3=24'hFF0000, h=100, v=100, state PLAY -> pixel_out=24'h00FF00 exactly 2 cycles later, with hcount_out=100.
- IR commit: ir_in=32'h20DF_5BA4 with ir_valid_in at mid-frame -> state stays START until the nf_in edge, then screen_state_out=1. A second strobe in the same frame causes no further change.
- Border and field: in PLAY at h=960, v=200 -> BORDER_COLOR. At h=961, v=200 -> 0. At h=500, v=640 -> BORDER_COLOR.
- Hit flash: FLASH_FRAMES=8; hit_in in PLAY with composite 24'h204060 -> 24'hFF2030 for 8 frames, then 24'h204060. A hit coincident with nf_in on frame 3 reloads the count to 8.
- Game over: game_over_in=1 in PLAY -> OVER after the next nf_in, composite 24'h80C040 -> 24'h406020. A valid START_CODE_B strobe then returns the state to START on the following nf_in.
